// File: rtl/spi_arbiter.sv
// spi_arbiter: round-robin arbiter that shares one word-level spi_controller
// among several clients, routes each response word back to its owner, and
// recovers from a controller that never answers by way of a per-transaction
// timeout.
module spi_arbiter #(
    parameter int NUM_REQUESTERS          = 4,
    parameter int TRANSACTION_LENGTH_BITS = 8,
    parameter int TIMEOUT_CYCLES          = 4096
) (
    input  logic                                               clk,
    input  logic                                               rst,
    input  logic [NUM_REQUESTERS-1:0]                          req_axiiv,
    input  logic [NUM_REQUESTERS*TRANSACTION_LENGTH_BITS-1:0]  req_axiid,
    output logic [NUM_REQUESTERS-1:0]                          req_accept,
    output logic [NUM_REQUESTERS-1:0]                          req_axiov,
    output logic [TRANSACTION_LENGTH_BITS-1:0]                 req_axiod,
    output logic [NUM_REQUESTERS-1:0]                          timeout_err,
    output logic                                               busy,
    output logic [$clog2(NUM_REQUESTERS)-1:0]                  owner,
    output logic                                               spi_axiiv,
    output logic [TRANSACTION_LENGTH_BITS-1:0]                 spi_axiid,
    input  logic                                               spi_axiready,
    input  logic                                               spi_axiov,
    input  logic [TRANSACTION_LENGTH_BITS-1:0]                 spi_axiod
);

    localparam int PTR_W   = $clog2(NUM_REQUESTERS);
    localparam int W       = TRANSACTION_LENGTH_BITS;
    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] ISSUE     = 2'd1;
    localparam logic [1:0] WAIT_RESP = 2'd2;
    localparam logic [1:0] DRAIN     = 2'd3;

    logic [1:0]         state;
    logic [PTR_W-1:0]   rr_ptr;
    logic [TIMER_W-1:0] timer;

    logic               found;
    logic [PTR_W-1:0]   winner;
    logic [PTR_W:0]     idx;
    logic [PTR_W-1:0]   next_ptr;
    logic [W-1:0]       winner_word;

    // Search upward from rr_ptr, wrapping, for the first client with a request.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            idx = {1'b0, rr_ptr} + (PTR_W+1)'(i);
            if (idx >= (PTR_W+1)'(NUM_REQUESTERS)) begin
                idx = idx - (PTR_W+1)'(NUM_REQUESTERS);
            end
            if (!found && req_axiiv[idx[PTR_W-1:0]]) begin
                found  = 1'b1;
                winner = idx[PTR_W-1:0];
            end
        end
    end

    assign winner_word = req_axiid[winner*W +: W];
    assign next_ptr    = (owner == PTR_W'(NUM_REQUESTERS - 1)) ? '0 : owner + PTR_W'(1);

    // Transaction sequencer: grant, issue one word, await response or timeout, drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            owner       <= '0;
            timer       <= '0;
            req_accept  <= '0;
            req_axiov   <= '0;
            req_axiod   <= '0;
            timeout_err <= '0;
            busy        <= 1'b0;
            spi_axiiv   <= 1'b0;
            spi_axiid   <= '0;
        end else begin
            req_accept  <= '0;
            req_axiov   <= '0;
            timeout_err <= '0;
            case (state)
                IDLE: begin
                    if (spi_axiready && found) begin
                        owner      <= winner;
                        spi_axiid  <= winner_word;
                        req_accept <= NUM_REQUESTERS'(1) << winner;
                        spi_axiiv  <= 1'b1;
                        busy       <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    spi_axiiv <= 1'b0;
                    timer     <= '0;
                    state     <= WAIT_RESP;
                end
                WAIT_RESP: begin
                    if (spi_axiov) begin
                        req_axiod <= spi_axiod;
                        req_axiov <= NUM_REQUESTERS'(1) << owner;
                        rr_ptr    <= next_ptr;
                        state     <= DRAIN;
                    end else if (timer == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
                        timeout_err <= NUM_REQUESTERS'(1) << owner;
                        rr_ptr      <= next_ptr;
                        state       <= DRAIN;
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
                end
                DRAIN: begin
                    if (spi_axiready) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    spi_axiiv <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_arbiter.sv
// tb_spi_arbiter: self-checking bench for spi_arbiter. The bench plays both
// the clients and the SPI controller; expected owners come from a round-robin
// model over the request mask, expected timeouts from the response delay.
module tb_spi_arbiter;

    localparam int N   = 4;
    localparam int W   = 8;
    localparam int TMO = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_axiiv;
    logic [N*W-1:0] req_axiid;
    logic [N-1:0]   req_accept;
    logic [N-1:0]   req_axiov;
    logic [W-1:0]   req_axiod;
    logic [N-1:0]   timeout_err;
    logic           busy;
    logic [1:0]     owner;
    logic           spi_axiiv;
    logic [W-1:0]   spi_axiid;
    logic           spi_axiready;
    logic           spi_axiov;
    logic [W-1:0]   spi_axiod;

    logic [W-1:0]   clientWord [N];

    int vectors     = 0;
    int miscompares = 0;
    int modelPtr    = 0;

    logic [N-1:0] rmask;
    int           expIdx;

    typedef struct {
        logic [N-1:0]   mask;
        logic [N*W-1:0] words;
        int             delay;
        logic [W-1:0]   resp;
        int             expOwner;
    } vec_t;

    vec_t table_v [6];

    int fairOrder [6] = '{0, 3, 0, 3, 0, 3};

    spi_arbiter #(
        .NUM_REQUESTERS(N),
        .TRANSACTION_LENGTH_BITS(W),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_axiiv(req_axiiv),
        .req_axiid(req_axiid),
        .req_accept(req_accept),
        .req_axiov(req_axiov),
        .req_axiod(req_axiod),
        .timeout_err(timeout_err),
        .busy(busy),
        .owner(owner),
        .spi_axiiv(spi_axiiv),
        .spi_axiid(spi_axiid),
        .spi_axiready(spi_axiready),
        .spi_axiov(spi_axiov),
        .spi_axiod(spi_axiod)
    );

    always #5 clk = ~clk;

    // Pack the per-client words onto the shared data bus.
    always_comb begin
        req_axiid = '0;
        for (int i = 0; i < N; i++) req_axiid[i*W +: W] = clientWord[i];
    end

    function automatic logic [N-1:0] oneHot(input int i);
        logic [N-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Round-robin rule: first requesting client at or after ptr, modulo N.
    function automatic int modelWinner(input logic [N-1:0] mask, input int ptr);
        for (int off = 0; off < N; off++) begin
            if (mask[(ptr + off) % N]) return (ptr + off) % N;
        end
        return -1;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 'h%0h, want 'h%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] mask, input logic [N*W-1:0] words);
        for (int i = 0; i < N; i++) clientWord[i] = words[i*W +: W];
        req_axiiv = mask;
    endtask

    // Called at a negedge: hold reset one edge, verify every output is zero, release.
    task automatic doReset();
        rst       = 1'b1;
        req_axiiv = '0;
        spi_axiov = 1'b0;
        @(negedge clk);
        checkOutput("reset outputs",
                    32'({req_accept, req_axiov, req_axiod, timeout_err, busy, owner, spi_axiiv, spi_axiid}),
                    32'd0);
        @(negedge clk);
        rst          = 1'b0;
        spi_axiready = 1'b1;
        modelPtr     = 0;
    endtask

    // One full transaction as seen from a controller that answers 'delay' cycles
    // after the issue cycle, or never if delay exceeds the timeout window.
    task automatic serveTransaction(input int expOwner, input int delay, input logic [W-1:0] resp,
                                    input bit dropOnAccept);
        bit got;
        bit respond;
        bit spurious;
        bit done;
        got      = 1'b0;
        spurious = 1'b0;
        done     = 1'b0;
        respond  = (delay <= TMO);
        for (int w = 0; w < 8 && !got; w++) begin
            @(negedge clk);
            if (req_accept != '0) got = 1'b1;
        end
        checkOutput("grant seen", 32'(got), 32'd1);
        if (!got) return;
        checkOutput("accept onehot", 32'(req_accept), 32'(oneHot(expOwner)));
        checkOutput("owner", 32'(owner), 32'(expOwner));
        checkOutput("issue word", 32'({spi_axiiv, spi_axiid}), 32'({1'b1, clientWord[expOwner]}));
        checkOutput("busy in issue", 32'(busy), 32'd1);
        if (dropOnAccept) req_axiiv[expOwner] = 1'b0;
        spi_axiready = 1'b0;
        // k counts cycles after the issue cycle; the timer reads k-1 in cycle k.
        for (int k = 1; k <= TMO + 1 && !done; k++) begin
            @(negedge clk);
            if (k == 1) begin
                checkOutput("single issue pulse", 32'({spi_axiiv, req_accept}), 32'd0);
            end
            if (respond && k == delay + 1) begin
                spi_axiov = 1'b0;
                checkOutput("resp valid", 32'(req_axiov), 32'(oneHot(expOwner)));
                checkOutput("resp data", 32'(req_axiod), 32'(resp));
                checkOutput("no timeout on resp", 32'(timeout_err), 32'd0);
                done = 1'b1;
            end else if (!respond && k == TMO + 1) begin
                checkOutput("timeout err", 32'(timeout_err), 32'(oneHot(expOwner)));
                checkOutput("no resp on timeout", 32'(req_axiov), 32'd0);
                done = 1'b1;
            end else begin
                if (req_axiov != '0 || timeout_err != '0 || (k > 1 && req_accept != '0)) spurious = 1'b1;
                if (respond && k == delay) begin
                    spi_axiov = 1'b1;
                    spi_axiod = resp;
                end
            end
        end
        checkOutput("no stray pulses", 32'(spurious), 32'd0);
        modelPtr = (expOwner + 1) % N;
        @(negedge clk);
        checkOutput("drain pulses clear", 32'({req_axiov, timeout_err, req_accept}), 32'd0);
        checkOutput("busy in drain", 32'(busy), 32'd1);
        spi_axiready = 1'b1;
        @(negedge clk);
        checkOutput("idle after drain", 32'(busy), 32'd0);
    endtask

    initial begin
        table_v[0] = '{4'b0100, 32'h11_A5_22_33, 3,  8'h3C, 2};
        table_v[1] = '{4'b0011, 32'h00_00_5B_4A, 16, 8'h5A, 0};
        table_v[2] = '{4'b1010, 32'hC3_00_96_00, 99, 8'h00, 1};
        table_v[3] = '{4'b1010, 32'h77_00_66_00, 1,  8'hFF, 3};
        table_v[4] = '{4'b0110, 32'h00_E1_D2_00, 5,  8'h00, 1};
        table_v[5] = '{4'b1111, 32'h44_33_22_11, 17, 8'h00, 2};

        rst          = 1'b1;
        req_axiiv    = '0;
        spi_axiready = 1'b1;
        spi_axiov    = 1'b0;
        spi_axiod    = '0;
        for (int i = 0; i < N; i++) clientWord[i] = '0;
        doReset();

        // Directed transactions: response, response on last timer cycle, timeouts.
        for (int r = 0; r < 6; r++) begin
            @(negedge clk);
            applyStimulus(table_v[r].mask, table_v[r].words);
            serveTransaction(table_v[r].expOwner, table_v[r].delay, table_v[r].resp, 1'b1);
            req_axiiv = '0;
        end

        // All four clients request together from reset: order 0,1,2,3.
        @(negedge clk);
        doReset();
        applyStimulus(4'b1111, 32'h9D_8C_7B_6A);
        for (int g = 0; g < N; g++) serveTransaction(g, 2 + g, 8'(8'h50 + g), 1'b1);

        // Fairness: clients 0 and 3 hold continuously.
        applyStimulus(4'b1001, 32'hF3_00_00_F0);
        for (int g = 0; g < 6; g++) serveTransaction(fairOrder[g], 4, 8'(8'hA0 + g), 1'b0);
        req_axiiv = '0;

        // No grant while the controller is not ready.
        begin
            bit granted;
            granted = 1'b0;
            @(negedge clk);
            spi_axiready = 1'b0;
            applyStimulus(4'b0010, 32'h00_00_B7_00);
            repeat (4) begin
                @(negedge clk);
                if (req_accept != '0 || busy || spi_axiiv) granted = 1'b1;
            end
            checkOutput("no grant without ready", 32'(granted), 32'd0);
            spi_axiready = 1'b1;
            serveTransaction(modelWinner(4'b0010, modelPtr), 6, 8'h81, 1'b1);
            req_axiiv = '0;
        end

        // Reset while waiting for a response, then a normal grant from rr_ptr 0.
        begin
            bit got;
            got = 1'b0;
            @(negedge clk);
            applyStimulus(4'b0100, 32'h00_E7_00_00);
            for (int w = 0; w < 8 && !got; w++) begin
                @(negedge clk);
                if (req_accept != '0) got = 1'b1;
            end
            checkOutput("grant before reset", 32'(got), 32'd1);
            req_axiiv    = '0;
            spi_axiready = 1'b0;
            repeat (3) @(negedge clk);
            doReset();
            applyStimulus(4'b1010, 32'h2B_00_1A_00);
            serveTransaction(modelWinner(4'b1010, modelPtr), 3, 8'h6E, 1'b1);
            req_axiiv = '0;
        end

        // Randomized traffic: clients join at random and hold until accepted.
        for (int t = 0; t < 40; t++) begin
            rmask = req_axiiv;
            for (int c = 0; c < N; c++) begin
                if (!rmask[c] && $urandom_range(0, 1) == 1) begin
                    rmask[c]      = 1'b1;
                    clientWord[c] = 8'($urandom);
                end
            end
            if (rmask == '0) begin
                rmask[t % N]      = 1'b1;
                clientWord[t % N] = 8'($urandom);
            end
            req_axiiv = rmask;
            expIdx    = modelWinner(rmask, modelPtr);
            serveTransaction(expIdx, int'($urandom_range(1, 20)), 8'($urandom), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
